// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage bus bundle (i-cache port, pipeline control, IF/ID register)
//   master (fetch stage): drives i_cache_read/i_cache_address, fetch_ready, if_id_pc/instr/valid
//                         receives i_cache_rdata/i_cache_resp, stall, redirect/redirect_pc
//   slave  (environment): the mirror image
interface fetch_stage_if;
    logic        i_cache_read;
    logic [31:0] i_cache_address;
    logic [31:0] i_cache_rdata;
    logic        i_cache_resp;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    modport master (
        output i_cache_read, i_cache_address, fetch_ready, if_id_pc, if_id_instr, if_id_valid,
        input  i_cache_rdata, i_cache_resp, stall, redirect, redirect_pc
    );
    modport slave (
        input  i_cache_read, i_cache_address, fetch_ready, if_id_pc, if_id_instr, if_id_valid,
        output i_cache_rdata, i_cache_resp, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch; owns the PC, reads the i-cache, fills IF/ID
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master (i-cache request/response, stall, redirect, IF/ID outputs)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {FETCH, READY, DRAIN} state_t;
    state_t      state_q;
    logic [31:0] pc_q, pend_q, buf_q, id_pc_q, id_instr_q;
    logic        id_valid_q;
    logic [31:0] tgt;
    assign tgt                 = {bus.redirect_pc[31:2], 2'b00};
    assign bus.fetch_ready     = (state_q == FETCH && bus.i_cache_resp) || state_q == READY;
    assign bus.i_cache_read    = !rst && state_q != READY;
    // in DRAIN pc_q still holds the in-flight address; the redirect target waits in pend_q
    assign bus.i_cache_address = pc_q;
    assign bus.if_id_pc        = id_pc_q;
    assign bus.if_id_instr     = id_instr_q;
    assign bus.if_id_valid     = id_valid_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            buf_q      <= '0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else if (bus.redirect && !bus.stall) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            // an unanswered request must complete before the target can be issued
            if (state_q != READY && !bus.i_cache_resp) begin
                pend_q  <= tgt;
                state_q <= DRAIN;
            end else begin
                pc_q    <= tgt;
                state_q <= FETCH;
            end
        end else begin
            case (state_q)
                FETCH: if (bus.i_cache_resp) begin
                    if (!bus.stall) begin
                        id_pc_q    <= pc_q;
                        id_instr_q <= bus.i_cache_rdata;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_q + 32'd4;
                    end else begin
                        buf_q   <= bus.i_cache_rdata;
                        state_q <= READY;
                    end
                end
                READY: if (!bus.stall) begin
                    id_pc_q    <= pc_q;
                    id_instr_q <= buf_q;
                    id_valid_q <= 1'b1;
                    pc_q       <= pc_q + 32'd4;
                    state_q    <= FETCH;
                end
                DRAIN: if (bus.i_cache_resp) begin
                    pc_q    <= pend_q;
                    state_q <= FETCH;
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a program-order model
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0060;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int checks   = 0;
    int failures = 0;
    typedef struct packed {logic v; logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t sb[$];
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask
    // reference: m_pc is the next instruction in program order, m_held means one has
    // arrived but not been consumed, m_disc means the outstanding reply is stale
    initial begin
        logic [31:0] m_pc, m_next, m_instr;
        logic m_held, m_disc;
        m_pc = RST_PC; m_next = '0; m_instr = '0; m_held = 1'b0; m_disc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("read_in_reset", 32'(bus.i_cache_read), 32'd0);
                m_pc = RST_PC; m_held = 1'b0; m_disc = 1'b0;
            end else begin
                chk("i_cache_read", 32'(bus.i_cache_read), 32'(!m_held));
                if (!m_held) chk("i_cache_address", bus.i_cache_address, m_pc);
                chk("fetch_ready", 32'(bus.fetch_ready), 32'(m_held || (bus.i_cache_resp && !m_disc)));
                if (bus.redirect && !bus.stall) begin
                    sb.push_back('{1'b0, 32'h0, NOP});
                    if (!m_held && !bus.i_cache_resp) begin
                        m_disc = 1'b1;
                        m_next = bus.redirect_pc & ~32'h3;
                    end else begin
                        m_pc = bus.redirect_pc & ~32'h3;
                        m_disc = 1'b0;
                        m_held = 1'b0;
                    end
                end else if (m_held) begin
                    if (!bus.stall) begin
                        sb.push_back('{1'b1, m_pc, m_instr});
                        m_pc = m_pc + 32'd4;
                        m_held = 1'b0;
                    end
                end else if (bus.i_cache_resp) begin
                    if (m_disc) begin
                        m_pc = m_next;
                        m_disc = 1'b0;
                    end else if (!bus.stall) begin
                        sb.push_back('{1'b1, m_pc, mem(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end else begin
                        m_held = 1'b1;
                        m_instr = mem(m_pc);
                    end
                end
            end
        end
    end
    // monitor: a transfer is fetch_ready&~stall or a redirect&~stall; otherwise IF/ID must hold
    initial begin
        ent_t last;
        logic xfer, rprev, live;
        last = '{1'b0, 32'h0, NOP}; xfer = 1'b0; rprev = 1'b0; live = 1'b0;
        forever begin
            @(negedge clk);
            if (rprev) begin
                last = '{1'b0, 32'h0, NOP};
                chk("reset_if_id_pc", bus.if_id_pc, 32'h0);
                live = 1'b1;
            end else if (xfer) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_transfer: got pc %h instr %h, want none", bus.if_id_pc, bus.if_id_instr);
                end else last = sb.pop_front();
            end
            if (live) begin
                chk("if_id_valid", 32'(bus.if_id_valid), 32'(last.v));
                chk("if_id_instr", bus.if_id_instr, last.instr);
                if (last.v) chk("if_id_pc", bus.if_id_pc, last.pc);
            end
            xfer = !rst && !bus.stall && (bus.redirect || bus.fetch_ready);
            rprev = rst;
        end
    end
    task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rp, input logic re);
        rst = r;
        bus.stall = st;
        bus.redirect = rd;
        bus.redirect_pc = rp;
        #1;
        bus.i_cache_resp = re && bus.i_cache_read;
        bus.i_cache_rdata = bus.i_cache_resp ? mem(bus.i_cache_address) : $urandom;
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.i_cache_resp = 1'b0; bus.i_cache_rdata = '0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h203, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h300, 0); cyc(0, 0, 1, 32'h400, 0); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h500, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'hFFFF_FFFE, 0); cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h800, 0); cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 500) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 3) != 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I 5-stage pipeline. It owns the PC, issues reads to the instruction cache and produces the IF/ID instruction register. Its output feeds the decoder, which produces the new control word for the pipeline control-word controller.
- It absorbs i-cache latency with a one-entry buffer and applies EX-resolved branch/jump redirects. A request that is already in flight when a redirect arrives is drained and its response discarded.

Parameters:
RESET_PC, 32'h00000060, PC value loaded on reset
NOP_INSTR, 32'h00000013, instruction word presented in IF/ID when the register holds a bubble (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset
i_cache_read  out  1  i-cache read request; held high until i_cache_resp
i_cache_address  out  32  i-cache word address
i_cache_rdata  in  32  i-cache read data; valid when i_cache_resp=1
i_cache_resp  in  1  i-cache response, single-cycle pulse
stall  in  1  stall from non-fetch sources (d-cache etc.); 1 = pipeline holds
redirect  in  1  taken branch/jump resolved in EX
redirect_pc  in  32  redirect target
fetch_ready  out  1  an instruction is available to advance this cycle
if_id_pc  out  32  PC of the instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
Reset and registers:
- rst is synchronous, active-high; clock is clk.
- On reset: pc=RESET_PC, state=FETCH, buffer empty, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
- i_cache_read is forced to 0 in any cycle with rst=1.
- Reset mid-request abandons the outstanding request. The i-cache is reset in the same cycle.

Advance rule:
- advance = fetch_ready & ~stall.
- fetch_ready = (state==FETCH & i_cache_resp) | (state==READY).

State FETCH:
- i_cache_read=1, i_cache_address=pc.
- On i_cache_resp with advance: IF/ID <= {pc, rdata, valid=1}; pc<=pc+4; stay FETCH. This is the zero-bubble bypass path.
- On i_cache_resp with stall=1: buffer <= {pc, rdata}; go READY.

State READY:
- i_cache_read=0.
- On advance: IF/ID <= buffer; pc<=pc+4; go FETCH.
- While stall=1: hold everything.

State DRAIN:
- i_cache_read=1, i_cache_address = old pc, unchanged from the request already in flight.
- fetch_ready=0.
- On i_cache_resp: discard data; pc<=pending_pc; go FETCH.

Redirect:
- Sampled only when stall=0, and has priority over every other event.
- IF/ID <= bubble (valid=0, instr=NOP_INSTR); the buffer is cleared.
- Target is redirect_pc with bits [1:0] forced to 00.
- From FETCH without resp: pending_pc<=target; go DRAIN.
- From FETCH with resp in the same cycle, or from READY: pc<=target; go FETCH (the response data, if any, is discarded).
- In DRAIN: pending_pc is overwritten by the newest target.

Hold and idle:
- While stall=1, IF/ID holds its contents, including its valid bit.
- If stall=0 and fetch_ready=0 (fetch stall) and there is no redirect, IF/ID holds its contents. The pipeline controller stalls on ~fetch_ready, so IF/ID must not change.

Arithmetic and latency:
- pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
- Throughput is one instruction per i_cache_resp.
- Resp-to-IF/ID latency is 1 clock edge when not stalled.

Test Plan:
- Reset, then a cache that responds 1 cycle after each read with instr=addr -> i_cache_address 0x60, 0x64, 0x68. IF/ID shows pc 0x60/instr 0x60, valid=1, on the edge after the first resp. No duplicated or skipped PCs.
- stall=1 asserted during the resp for pc 0x64 and held 3 cycles -> state READY, i_cache_read=0, fetch_ready=1, IF/ID unchanged. On release, IF/ID=0x64 and the next request is 0x68.
- redirect=1, redirect_pc=0x203 while the request for 0x70 is outstanding (no resp) -> IF/ID becomes a bubble (NOP_INSTR, valid=0) and address stays 0x70 until resp. The 0x70 data never reaches IF/ID; the next request is 0x200.
- Two redirects while draining (0x300 then 0x400) -> after the drain resp, the next request is 0x400.
- redirect in the same cycle as a resp in FETCH, with stall=0 -> the response is dropped and the next-cycle address is the target.
- PC=0xFFFFFFFC fetched -> next address 0x00000000. Assert rst during DRAIN -> next cycle pc=0x60, IF/ID bubble, i_cache_read=0 during reset.
